// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_tx
//  Description : Mono 16-bit PCM to I2S transmitter. Samples are buffered in a
//                4-entry FIFO and one sample is sent on both the left and the
//                right channel of each 32-bit I2S frame. Bit clock is derived
//                from the system clock via a half-period divider.
//  Option      : `define AUDIO_I2S_TX_UNDERRUN_HOLD_EN to repeat the last
//                popped sample on an underrun instead of sending silence.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_i2s_tx #(
    parameter int BCLK_DIV = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    input  logic        clear_flags,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic [2:0]  fifo_level,
    output logic        overflow,
    output logic        underrun
);

    localparam logic [7:0] DIV_LAST   = 8'(BCLK_DIV - 1);
    localparam logic [2:0] FIFO_DEPTH = 3'd4;

    // Bit clock divider
    logic [7:0]  div_q, div_d;
    logic        bclk_q, bclk_d;

    // Serializer
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] frame_q, frame_d;
    logic        lrclk_q, lrclk_d;
    logic        sdata_q, sdata_d;

    // Sample FIFO
    logic [15:0] mem_q [4];
    logic [15:0] mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  level_q, level_d;

    // Sticky status
    logic        overflow_q, overflow_d;
    logic        underrun_q, underrun_d;

    // Event strobes
    logic        w_div_tick;
    logic        w_fall_tick;
    logic        w_frame_start;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_underrun_evt;
    logic [15:0] w_head;
    logic [15:0] w_fill;
    logic [4:0]  w_bit_after;

`ifdef AUDIO_I2S_TX_UNDERRUN_HOLD_EN
    logic [15:0] last_q, last_d;

    // Remember the most recent sample actually taken from the FIFO
    always_comb begin
        last_d = last_q;
        if (w_pop) begin
            last_d = w_head;
        end
    end

    // Holding register for the repeat-on-underrun fill value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end

    assign w_fill = last_q;
`else
    assign w_fill = 16'h0000;
`endif

    // Decode the divider wrap, the bit-clock falling edge and FIFO events
    always_comb begin
        w_div_tick     = (div_q == DIV_LAST);
        // A tick while bclk is high is the 1->0 toggle
        w_fall_tick    = w_div_tick & bclk_q;
        w_frame_start  = w_fall_tick && (bit_cnt_q == 5'd31);
        w_fifo_empty   = (level_q == 3'd0);
        w_fifo_full    = (level_q == FIFO_DEPTH);
        w_head         = mem_q[rd_ptr_q];
        // Pop sees the FIFO as it was before this cycle: no bypass of a push
        w_pop          = w_frame_start && !w_fifo_empty;
        // A pop in the same cycle frees the slot a full FIFO needs
        w_push         = sample_valid && (!w_fifo_full || w_pop);
        w_drop         = sample_valid && !w_push;
        w_underrun_evt = w_frame_start && w_fifo_empty;
    end

    // Half-period divider that toggles the bit clock
    always_comb begin
        div_d  = div_q + 8'd1;
        bclk_d = bclk_q;
        if (w_div_tick) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end
    end

    // Advance the bit position and shift out data on each falling tick
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        // Word select leads the data by one bit: it follows bit_cnt+1 of
        // the new position, i.e. the current position plus two
        w_bit_after = bit_cnt_q + 5'd2;
        if (w_fall_tick) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (w_frame_start) begin
                frame_d = w_pop ? w_head : w_fill;
            end
            // ~b[3:0] == 15 - (b mod 16): MSB first within each channel word
            sdata_d = frame_d[~bit_cnt_d[3:0]];
            lrclk_d = w_bit_after[4];
        end
    end

    // FIFO storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = sample_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        level_d = level_q + {2'b00, w_push} - {2'b00, w_pop};
    end

    // Sticky flags: a set event in the same cycle wins over clear
    always_comb begin
        overflow_d = (overflow_q & ~clear_flags) | w_drop;
        underrun_d = (underrun_q & ~clear_flags) | w_underrun_evt;
    end

    // State registers; reset abandons any buffered samples and partial frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= 5'd31;
            frame_q    <= '0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = sdata_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_i2s_tx
//  Description : Self-checking bench for audio_i2s_tx. A queue-based model
//                predicts FIFO occupancy, flags and the word stream; an I2S
//                receiver decodes the serial output and compares every word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;

    localparam int D = 2;           // BCLK_DIV under test
    localparam int F = 64 * D;      // clocks per 32-bit frame
    localparam int B = 2 * D;       // frame-start phase after reset release

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = 16'h0000;
    logic        clear_flags = 1'b0;
    logic        i2s_bclk, i2s_lrclk, i2s_sdata;
    logic [2:0]  fifo_level;
    logic        overflow, underrun;

    int checks = 0;
    int errors = 0;

    audio_i2s_tx #(.BCLK_DIV(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .clear_flags  (clear_flags),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .underrun     (underrun)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [15:0] q_m[$];
    logic [15:0] exp_words[$];
    logic        ov_m, ur_m;
    logic [15:0] last_m;
    int          cyc;
    logic [15:0] mv;
    logic        set_ov, set_ur;

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                q_m.delete(); exp_words.delete();
                ov_m = 1'b0; ur_m = 1'b0; last_m = '0; cyc = 0;
            end else begin
                cyc++;
                set_ov = 1'b0; set_ur = 1'b0;
                if (cyc % F == B) begin
                    if (q_m.size() > 0) begin
                        mv = q_m.pop_front(); last_m = mv;
                    end else begin
                        set_ur = 1'b1;
`ifdef AUDIO_I2S_TX_UNDERRUN_HOLD_EN
                        mv = last_m;
`else
                        mv = 16'h0000;
`endif
                    end
                    exp_words.push_back(mv);
                    exp_words.push_back(mv);
                end
                if (sample_valid) begin
                    if (q_m.size() < 4) q_m.push_back(sample_data);
                    else set_ov = 1'b1;
                end
                if (clear_flags) begin ov_m = 1'b0; ur_m = 1'b0; end
                if (set_ov) ov_m = 1'b1;
                if (set_ur) ur_m = 1'b1;
            end
        end
    end

    // ---------------- per-cycle status monitor ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                checks++;
                if (fifo_level !== 3'(q_m.size())) begin
                    errors++;
                    $display("FAIL mon_level cyc=%0d: got %0d, expected %0d", cyc, fifo_level, q_m.size());
                end
                checks++;
                if (overflow !== ov_m) begin
                    errors++;
                    $display("FAIL mon_overflow cyc=%0d: got %b, expected %b", cyc, overflow, ov_m);
                end
                checks++;
                if (underrun !== ur_m) begin
                    errors++;
                    $display("FAIL mon_underrun cyc=%0d: got %b, expected %b", cyc, underrun, ur_m);
                end
            end
        end
    end

    // ---------------- I2S receiver ----------------
    logic        bclk_prev, lr_prev;
    logic [15:0] sr, ew;
    int          nbits;
    int          words_rx = 0;
    logic [15:0] rx_left[$];
    logic [15:0] last_right;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                bclk_prev = 1'b0; lr_prev = 1'b0; sr = '0; nbits = 0;
            end else begin
                if (i2s_bclk && !bclk_prev) begin
                    sr = {sr[14:0], i2s_sdata};
                    nbits++;
                    if (i2s_lrclk !== lr_prev) begin
                        if (nbits >= 16) begin
                            words_rx++;
                            if (!lr_prev) rx_left.push_back(sr);
                            else last_right = sr;
                            checks++;
                            if (exp_words.size() == 0) begin
                                errors++;
                                $display("FAIL rx_word: got %h, expected no word", sr);
                            end else begin
                                ew = exp_words.pop_front();
                                if (sr !== ew) begin
                                    errors++;
                                    $display("FAIL rx_word ch=%0d: got %h, expected %h", lr_prev, sr, ew);
                                end
                            end
                        end
                        nbits = 0;
                    end
                    lr_prev = i2s_lrclk;
                end
                bclk_prev = i2s_bclk;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic goto_phase(input int p);
        int n;
        n = 0;
        @(negedge clock);
        while (cyc % F != p && n < 2 * F) begin
            @(negedge clock);
            n++;
        end
        if (cyc % F != p) begin
            checks++; errors++;
            $display("FAIL goto_phase: got phase %0d, expected %0d", cyc % F, p);
        end
    endtask

    task automatic push(input logic [15:0] d);
        sample_valid = 1'b1; sample_data = d;
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clock);
        clear_flags = 1'b0;
    endtask

    task automatic wait_left(input int n, input int limit);
        int k;
        k = 0;
        while (rx_left.size() < n && k < limit) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (rx_left.size() < n) begin
            errors++;
            $display("FAIL wait_left: got %0d words, expected %0d", rx_left.size(), n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (i2s_bclk !== 1'b0)   begin errors++; $display("FAIL reset_bclk: got %b, expected 0", i2s_bclk); end
        checks++; if (i2s_lrclk !== 1'b0)  begin errors++; $display("FAIL reset_lrclk: got %b, expected 0", i2s_lrclk); end
        checks++; if (i2s_sdata !== 1'b0)  begin errors++; $display("FAIL reset_sdata: got %b, expected 0", i2s_sdata); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d, expected 0", fifo_level); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        checks++; if (underrun !== 1'b0)   begin errors++; $display("FAIL reset_underrun: got %b, expected 0", underrun); end
    endtask

    task automatic test_first_frame();
        int w0;
        rx_left.delete();
        w0 = words_rx;
        reset = 1'b0;
        push(16'hA5C3);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL ff_level_push: got %0d, expected 1", fifo_level); end
        goto_phase(B);
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ff_level_pop: got %0d, expected 0", fifo_level); end
        checks++; if (i2s_sdata !== 1'b1)  begin errors++; $display("FAIL ff_msb: got %b, expected 1", i2s_sdata); end
        checks++; if (i2s_lrclk !== 1'b0)  begin errors++; $display("FAIL ff_lr_bit0: got %b, expected 0", i2s_lrclk); end
        goto_phase(B + 14 * B);
        checks++; if (i2s_lrclk !== 1'b0)  begin errors++; $display("FAIL ff_lr_bit14: got %b, expected 0", i2s_lrclk); end
        goto_phase(B + 15 * B);
        checks++; if (i2s_lrclk !== 1'b1)  begin errors++; $display("FAIL ff_lr_bit15: got %b, expected 1", i2s_lrclk); end
        goto_phase(0);
        checks++; if (i2s_lrclk !== 1'b0)  begin errors++; $display("FAIL ff_lr_bit31: got %b, expected 0", i2s_lrclk); end
        repeat (4 * D) @(negedge clock);
        checks++;
        if (words_rx < w0 + 2) begin
            errors++; $display("FAIL ff_words: got %0d, expected %0d", words_rx - w0, 2);
        end else begin
            checks++; if (rx_left[0] !== 16'hA5C3)  begin errors++; $display("FAIL ff_left: got %h, expected a5c3", rx_left[0]); end
            checks++; if (last_right !== 16'hA5C3) begin errors++; $display("FAIL ff_right: got %h, expected a5c3", last_right); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] vals [6];
        goto_phase(B + 4);
        pulse_clear();
        for (int i = 0; i < 6; i++) begin
            vals[i] = 16'($urandom);
            push(vals[i]);
            sample_valid = 1'b0;
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d, expected 4", fifo_level); end
        checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
        goto_phase(B);
        rx_left.delete();
        wait_left(4, 6 * F);
        if (rx_left.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_left[i] !== vals[i]) begin
                    errors++; $display("FAIL ovf_order[%0d]: got %h, expected %h", i, rx_left[i], vals[i]);
                end
            end
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drained: got %0d, expected 0", fifo_level); end
    endtask

    task automatic test_underrun();
        logic [15:0] fill;
        pulse_clear();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_cleared: got %b, expected 0", underrun); end
        push(16'h1234);
        goto_phase(B);
        checks++; if (underrun !== 1'b0)   begin errors++; $display("FAIL ur_first: got %b, expected 0", underrun); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ur_level: got %0d, expected 0", fifo_level); end
        rx_left.delete();
        goto_phase(B);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_second: got %b, expected 1", underrun); end
`ifdef AUDIO_I2S_TX_UNDERRUN_HOLD_EN
        fill = 16'h1234;
`else
        fill = 16'h0000;
`endif
        wait_left(2, 2 * F);
        if (rx_left.size() >= 2) begin
            checks++; if (rx_left[0] !== 16'h1234) begin errors++; $display("FAIL ur_word1: got %h, expected 1234", rx_left[0]); end
            checks++; if (rx_left[1] !== fill)     begin errors++; $display("FAIL ur_fill: got %h, expected %h", rx_left[1], fill); end
        end
    endtask

    task automatic test_pop_collision();
        pulse_clear();
        for (int i = 0; i < 4; i++) push(16'($urandom));
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL col_fill: got %0d, expected 4", fifo_level); end
        goto_phase(B - 1);
        push(16'hBEEF);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL col_full_level: got %0d, expected 4", fifo_level); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL col_full_ovf: got %b, expected 0", overflow); end
        repeat (4) goto_phase(B);
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL col_drain: got %0d, expected 0", fifo_level); end
        pulse_clear();
        goto_phase(B - 1);
        push(16'h0F0F);
        checks++; if (underrun !== 1'b1)   begin errors++; $display("FAIL col_empty_ur: got %b, expected 1", underrun); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL col_empty_level: got %0d, expected 1", fifo_level); end
    endtask

    task automatic test_clear();
        goto_phase(10);
        pulse_clear();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b, expected 0", overflow); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL clr_ur: got %b, expected 0", underrun); end
        for (int i = 0; i < 3; i++) push(16'($urandom));
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL clr_fill: got %0d, expected 4", fifo_level); end
        clear_flags = 1'b1;
        push(16'h5555);
        clear_flags = 1'b0;
        checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL clr_same_cycle: got %b, expected 1", overflow); end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL clr_level: got %0d, expected 4", fifo_level); end
        pulse_clear();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_after: got %b, expected 0", overflow); end
    endtask

    task automatic test_reset_mid();
        goto_phase(B);
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL rm_level3: got %0d, expected 3", fifo_level); end
        goto_phase(B + 7 * B + 1);
        reset = 1'b1;
        #1;
        checks++; if (i2s_bclk !== 1'b0)   begin errors++; $display("FAIL rm_bclk: got %b, expected 0", i2s_bclk); end
        checks++; if (i2s_lrclk !== 1'b0)  begin errors++; $display("FAIL rm_lrclk: got %b, expected 0", i2s_lrclk); end
        checks++; if (i2s_sdata !== 1'b0)  begin errors++; $display("FAIL rm_sdata: got %b, expected 0", i2s_sdata); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rm_level: got %0d, expected 0", fifo_level); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (B - 1) @(negedge clock);
        checks++; if (i2s_bclk !== 1'b1)  begin errors++; $display("FAIL rm_bclk_high: got %b, expected 1", i2s_bclk); end
        checks++; if (underrun !== 1'b0)  begin errors++; $display("FAIL rm_ur_early: got %b, expected 0", underrun); end
        @(negedge clock);
        checks++; if (i2s_bclk !== 1'b0)   begin errors++; $display("FAIL rm_bclk_fall: got %b, expected 0", i2s_bclk); end
        checks++; if (underrun !== 1'b1)   begin errors++; $display("FAIL rm_ur: got %b, expected 1", underrun); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rm_level_after: got %0d, expected 0", fifo_level); end
    endtask

    task automatic test_random();
        int pct;
        for (int seg = 0; seg < 4; seg++) begin
            pct = $urandom_range(0, 3);
            for (int c = 0; c < 800; c++) begin
                sample_valid = ($urandom_range(0, 99) < pct);
                sample_data  = 16'($urandom);
                clear_flags  = ($urandom_range(0, 49) == 0);
                @(negedge clock);
            end
        end
        sample_valid = 1'b0;
        clear_flags  = 1'b0;
        @(negedge clock);
        checks++;
        if (fifo_level !== 3'(q_m.size())) begin
            errors++; $display("FAIL rnd_level: got %0d, expected %0d", fifo_level, q_m.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_overflow();
        test_underrun();
        test_pop_collision();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 8: number of clock cycles per half-period of i2s_bclk, legal range 2..255.
REQ-002 SHALL have port clock, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port sample_valid, input, 1: one-cycle strobe meaning sample_data holds a new mono sample; no backpressure.
REQ-005 SHALL have port sample_data, input, 16: signed two's-complement PCM sample.
REQ-006 SHALL have port clear_flags, input, 1: clears the sticky overflow and underrun flags.
REQ-007 SHALL have port i2s_bclk, output, 1: serial bit clock.
REQ-008 SHALL have port i2s_lrclk, output, 1: word select; low = left, high = right.
REQ-009 SHALL have port i2s_sdata, output, 1: serial data, MSB first.
REQ-010 SHALL have port fifo_level, output, 3: current FIFO occupancy, 0..4.
REQ-011 SHALL have port overflow, output, 1: sticky flag, set when a sample is dropped.
REQ-012 SHALL have port underrun, output, 1: sticky flag, set when a frame starts with the FIFO empty.

Function
REQ-013 SHALL buffer samples in a 4-entry FIFO.
REQ-014 SHALL push sample_data when sample_valid=1 and the FIFO is not full.
REQ-015 SHALL, when sample_valid=1, the FIFO is full and no pop occurs in that cycle, drop the sample, leave the contents unchanged and set overflow.
REQ-016 SHALL, when push and pop coincide with the FIFO full, accept the push; level stays 4.
REQ-017 SHALL, when push and pop coincide with the FIFO empty, have the pop see empty (underrun; no bypass), then store the pushed sample; level becomes 1.
REQ-018 SHALL run a divider counter 0..BCLK_DIV-1, toggling i2s_bclk and restarting the counter when it reaches BCLK_DIV-1.
REQ-019 SHALL treat a toggle of i2s_bclk from 1 to 0 as a "falling tick".
REQ-020 SHALL have a 5-bit bit_cnt that increments (wrapping 31->0) on each falling tick.
REQ-021 SHALL drive i2s_lrclk as bit 4 of (bit_cnt+1): low for bit_cnt 31 and 0..14, high for 15..30, so the MSB appears one BCLK after each word-select edge.
REQ-022 SHALL, on the falling tick where bit_cnt wraps 31->0, pop the FIFO head into a 16-bit frame register; if the FIFO is empty, set underrun and load the fill value per the Configuration section.
REQ-023 SHALL drive i2s_sdata as frame[15 - (bit_cnt mod 16)], updating only on falling ticks; the same mono sample goes to both channels.
REQ-024 SHALL register i2s_sdata, i2s_lrclk and i2s_bclk (no combinational path from inputs).
REQ-025 SHALL make fifo_level reflect pushes and pops in the cycle after they occur.
REQ-026 SHALL, when clear_flags and a setting event occur in the same cycle, leave the flag set.

Reset
REQ-027 SHALL, while reset=1, force i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, fifo_level=0, overflow=0, underrun=0, divider=0, bit_cnt=31, frame=0, FIFO pointers=0.
REQ-028 SHALL discard FIFO contents and any partial frame when reset is asserted mid-frame; the first falling tick after release starts a fresh frame at bit_cnt=0.

Configuration
REQ-029 SHALL, with macro AUDIO_I2S_TX_UNDERRUN_HOLD_EN defined, load the last successfully popped sample on an underrun (0 if none popped since reset).
REQ-030 SHALL, without AUDIO_I2S_TX_UNDERRUN_HOLD_EN, load 16'h0000 on an underrun.
REQ-031 SHALL set underrun on an underrun pop in both configurations.

Verification
REQ-032 SHALL cover: BCLK_DIV=2, push 16'hA5C3 before the first frame -> i2s_lrclk low for bit_cnt 31 and 0..14; i2s_sdata sends 1010010111000011 on both channels; level 1->0.
REQ-033 SHALL cover: 6 back-to-back pushes with no pop -> level=4, overflow=1, entries 5-6 lost; next frames output samples 1..4 in order.
REQ-034 SHALL cover: push 16'h1234, then let two frames elapse -> second frame sets underrun; outputs 16'h1234 with AUDIO_I2S_TX_UNDERRUN_HOLD_EN, 16'h0000 without.
REQ-035 SHALL cover: sample_valid at the same cycle as the 31->0 pop with FIFO full -> level stays 4, no overflow; with FIFO empty -> underrun=1, level=1.
REQ-036 SHALL cover: clear_flags pulse with no event -> both flags 0; clear_flags in the same cycle as an overflow drop -> overflow stays 1.
REQ-037 SHALL cover: reset asserted at bit_cnt=7 with level 3 -> outputs immediately 0, level 0; after release, one BCLK period of 2*BCLK_DIV clocks, then a frame restarts at bit_cnt=0 with underrun.
